// File: rtl/fifo_ctrl_pkg.sv
// Shared types and width helpers for the FIFO write-arbiter / read-sequencer controller.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StFlush
    } rd_state_t;

    function automatic int unsigned lvl_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping, wins.
module rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int unsigned            cand;
    logic       [IDX_W-1:0] cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin writer arbitration onto a shared SyncFifo, with burst / flush read sequencing.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BURST = 4,
    localparam int unsigned LVL_W = lvl_width(DEPTH)
) (
    input  logic                   clk_sig,
    input  logic                   rst_sig,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   flush,
    output logic                   fifo_w_en,
    output logic [WIDTH-1:0]       fifo_data_in,
    output logic                   fifo_r_en,
    input  logic [WIDTH-1:0]       fifo_data_out,
    input  logic                   fifo_full,
    input  logic                   fifo_empty,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic [LVL_W-1:0]       level
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             eligible;
    logic             wr, rd;

    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] cnt_q, cnt_d;
    rd_state_t        state_q, state_d;
    logic             flush_pend_q, flush_pend_d;
    logic             out_valid_q, out_last_q;

    // Write side
    assign eligible = (level_q < LVL_W'(DEPTH)) && !fifo_full;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .req        (req_valid & {N_REQ{eligible}}),
        .ptr        (ptr_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign req_ready    = grant;
    assign wr           = grant_valid;
    assign fifo_w_en    = wr;
    assign fifo_data_in = req_data[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Occupancy
    assign rd = (state_q != StIdle);

    always_comb begin
        level_d = level_q;
        unique case ({wr, rd})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Read sequencer: a full burst always wins over a pending flush
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        unique case (state_q)
            StIdle: begin
                if (level_q >= LVL_W'(BURST)) begin
                    state_d = StBurst;
                    cnt_d   = LVL_W'(BURST);
                end else if (flush_pend_q) begin
                    flush_pend_d = 1'b0;
                    if (level_q != '0) begin
                        state_d = StFlush;
                        cnt_d   = level_q;
                    end
                end
            end
            StBurst, StFlush: begin
                cnt_d = cnt_q - LVL_W'(1);
                if (cnt_q == LVL_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A pulse arriving while a flush is being armed is kept for the next round
        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sig or posedge rst_sig) begin
        if (rst_sig) begin
            ptr_q        <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            state_q      <= StIdle;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= rd;
            out_last_q   <= rd && (cnt_q == LVL_W'(1));
        end
    end

    assign fifo_r_en = rd;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_valid_q ? fifo_data_out : '0;
    assign level     = level_q;

`ifndef SYNTHESIS
    a_no_read_empty : assert property (@(posedge clk_sig) disable iff (rst_sig)
        fifo_r_en |-> (!fifo_empty && level_q != '0));
    a_no_write_full : assert property (@(posedge clk_sig) disable iff (rst_sig)
        fifo_w_en |-> !fifo_full);
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench: fifo_wr_arbiter against a behavioural SyncFifo and a queue-based reference model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 8;
    localparam int B = 4;

    logic         clk_sig = 1'b0;
    logic         rst_sig = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_ready;
    logic         flush = 1'b0;
    logic         fifo_w_en, fifo_r_en, fifo_full, fifo_empty;
    logic [W-1:0] fifo_data_in, fifo_data_out;
    logic         out_valid, out_last;
    logic [W-1:0] out_data;
    logic [3:0]   level;

    fifo_wr_arbiter #(
        .N_REQ(N),
        .WIDTH(W),
        .DEPTH(D),
        .BURST(B)
    ) dut (
        .clk_sig      (clk_sig),
        .rst_sig      (rst_sig),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .flush        (flush),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .fifo_r_en    (fifo_r_en),
        .fifo_data_out(fifo_data_out),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .level        (level)
    );

    always #5 clk_sig = ~clk_sig;

    // Behavioural SyncFifo: registered data_out, valid the cycle after r_en
    logic [W-1:0] fmem[D];
    logic [2:0]   fwp, frp;
    logic [3:0]   fcnt;
    always_ff @(posedge clk_sig or posedge rst_sig) begin
        if (rst_sig) begin
            fwp <= '0;
            frp <= '0;
            fcnt <= '0;
            fifo_data_out <= '0;
        end else begin
            if (fifo_w_en) begin
                fmem[fwp] <= fifo_data_in;
                fwp <= fwp + 3'd1;
            end
            if (fifo_r_en) begin
                fifo_data_out <= fmem[frp];
                frp <= frp + 3'd1;
            end
            fcnt <= fcnt + 4'(fifo_w_en) - 4'(fifo_r_en);
        end
    end
    assign fifo_full  = (fcnt == 4'(D));
    assign fifo_empty = (fcnt == 4'd0);

    int checks = 0;
    int errors = 0;

    // Reference model: words held as a queue, read activity as "reads left to issue"
    logic [W-1:0] m_q[$];
    int           m_ptr, m_level, m_reads_left;
    bit           m_pend, m_ov, m_ol;
    logic [W-1:0] m_od;

    logic [W-1:0] obs_data[$];
    bit           obs_last[$];
    int           obs_grant[$];
    bit           saw_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr = 0;
        m_level = 0;
        m_reads_left = 0;
        m_pend = 0;
        m_ov = 0;
        m_ol = 0;
        m_od = '0;
        obs_data.delete();
        obs_last.delete();
        obs_grant.delete();
        saw_stall = 0;
    endtask

    // One clock cycle: drive, compare every output against the model, advance the model
    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit fl);
        int g;
        bit rdc;
        logic [N-1:0] exp_ready;
        @(negedge clk_sig);
        req_valid = v;
        req_data  = d;
        flush     = fl;
        #1;
        g = -1;
        if (m_level < D) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        rdc = (m_reads_left > 0);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("fifo_w_en", 32'(fifo_w_en), 32'(g >= 0));
        if (g >= 0) check("fifo_data_in", 32'(fifo_data_in), 32'(d[g*W +: W]));
        check("fifo_r_en", 32'(fifo_r_en), 32'(rdc));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
        check("out_last", 32'(out_last), 32'(m_ov && m_ol));
        check("level", 32'(level), 32'(m_level));
        check("w_en_on_full", 32'(fifo_w_en && fifo_full), 32'd0);
        check("r_en_on_empty", 32'(fifo_r_en && fifo_empty), 32'd0);

        if (out_valid) begin
            obs_data.push_back(out_data);
            obs_last.push_back(out_last);
        end
        for (int k = 0; k < N; k++) if (req_ready[k]) obs_grant.push_back(k);
        if (level == 4'(D) && v != '0 && req_ready == '0) saw_stall = 1;

        m_ov = rdc;
        m_ol = 0;
        if (rdc) begin
            m_od = m_q.pop_front();
            m_ol = (m_reads_left == 1);
            m_reads_left--;
        end else if (m_level >= B) begin
            m_reads_left = B;
        end else if (m_pend) begin
            m_pend = 0;
            m_reads_left = m_level;
        end
        if (g >= 0) begin
            m_q.push_back(d[g*W +: W]);
            m_ptr = (g + 1) % N;
        end
        m_level = m_level + ((g >= 0) ? 1 : 0) - (rdc ? 1 : 0);
        if (fl) m_pend = 1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk_sig);
        rst_sig   = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        #1;
        check({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rst_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_rst_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_rst_level"}, 32'(level), 32'd0);
        check({tag, "_rst_r_en"}, 32'(fifo_r_en), 32'd0);
        check({tag, "_rst_w_en"}, 32'(fifo_w_en), 32'd0);
        model_reset();
        @(negedge clk_sig);
        rst_sig = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] dd;
        model_reset();
        do_reset("init");

        // Single writer, one burst
        for (int i = 0; i < 4; i++) step(4'b0001, {24'h0, 8'(8'h11 + i)}, 1'b0);
        step('0, '0, 1'b0);
        check("t1_level_full_burst", 32'(level), 32'd4);
        step('0, '0, 1'b0);
        check("t1_first_read", 32'(fifo_r_en), 32'd1);
        idle(8);
        check("t1_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_data", 32'(obs_data[i]), 32'(8'h11 + i));
                check("t1_last", 32'(obs_last[i]), 32'(i == 3));
            end
        end
        check("t1_level_end", 32'(level), 32'd0);

        // All writers valid: rotation order and stall at full
        do_reset("t2");
        dd = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int i = 0; i < 40; i++) step(4'b1111, dd, 1'b0);
        for (int i = 0; i < 8; i++) check("t2_grant_order", obs_grant[i], i % 4);
        check("t2_saw_stall", 32'(saw_stall), 32'd1);
        step('0, '0, 1'b1);
        idle(30);
        check("t2_drained", 32'(level), 32'd0);

        // Flush of a partial load, then flush while empty
        do_reset("t3");
        for (int i = 0; i < 3; i++) step(4'b0010, {16'h0, 8'(8'h21 + i), 8'h0}, 1'b0);
        step('0, '0, 1'b1);
        idle(8);
        check("t3_count", obs_data.size(), 3);
        if (obs_data.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t3_data", 32'(obs_data[i]), 32'(8'h21 + i));
                check("t3_last", 32'(obs_last[i]), 32'(i == 2));
            end
        end
        step('0, '0, 1'b1);
        idle(6);
        check("t3_empty_flush_no_out", obs_data.size(), 3);

        // Reset during the second read of a burst, then a clean burst
        do_reset("t5a");
        for (int i = 0; i < 4; i++) step(4'b0100, {8'h0, 8'(8'h31 + i), 16'h0}, 1'b0);
        idle(2);
        do_reset("t5b");
        for (int i = 0; i < 4; i++) step(4'b0100, {8'h0, 8'(8'h51 + i), 16'h0}, 1'b0);
        idle(8);
        check("t5_count", obs_data.size(), 4);
        if (obs_data.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t5_data", 32'(obs_data[i]), 32'(8'h51 + i));
        end

        // Random valid / data / flush against the model
        do_reset("t6");
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            if ((i / 250) % 2 == 1) v = v & N'($urandom);
            step(v, {$urandom}, ($urandom_range(0, 39) == 0));
        end
        step('0, '0, 1'b1);
        idle(30);
        check("t6_drained", 32'(level), 32'd0);
        check("t6_model_empty", m_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
